// File: rtl/platform_msgq_pkg.sv
// platform_msgq_pkg: shared types and sizing helper for the RAM-backed message queue
package platform_msgq_pkg;
    typedef enum logic {IDLE, RD} state_e;
    typedef enum logic {GRANT_WR, GRANT_RD} grant_e;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/platform_ram_msgq.sv
// platform_ram_msgq: circular 32-bit message queue held in a window of single-port platform RAM
module platform_ram_msgq
    import platform_msgq_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_WORD = 0,
    parameter int DEPTH     = 256,
    parameter int CW        = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              push_valid,
    input  logic [31:0]       push_data,
    output logic              push_ready,
    output logic              pop_valid,
    output logic [31:0]       pop_data,
    input  logic              pop_ready,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata
);
    localparam int PW = $clog2(DEPTH);
    state_e        state_q, state_d;
    grant_e        last_grant_q, last_grant_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    logic          pop_valid_q, pop_valid_d;
    logic [31:0]   pop_data_q, pop_data_d;
    logic          want_wr, want_rd, grant_wr, grant_rd;
    // reset and clr both keep the RAM port idle
    assign want_wr  = reset_n & ~clr & push_valid & (ram_cnt_q < CW'(DEPTH));
    assign want_rd  = ~clr & (state_q == IDLE) & (ram_cnt_q != '0) & ~pop_valid_q;
    assign grant_wr = want_wr & ~(want_rd & (last_grant_q == GRANT_WR));
    assign grant_rd = want_rd & ~(want_wr & (last_grant_q == GRANT_RD));
    assign push_ready     = grant_wr;
    assign ram_chipselect = grant_wr | grant_rd;
    assign ram_write      = grant_wr;
    assign ram_address    = ADDR_W'(BASE_WORD) + ADDR_W'(grant_wr ? wr_ptr_q : rd_ptr_q);
    assign ram_byteenable = 4'hF;
    assign ram_writedata  = push_data;
    assign pop_valid      = pop_valid_q;
    assign pop_data       = pop_data_q;
    assign count          = ram_cnt_q + CW'(pop_valid_q) + CW'(state_q == RD);
    assign full           = ram_cnt_q == CW'(DEPTH);
    assign empty          = count == '0;
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_cnt_d    = ram_cnt_q;
        pop_valid_d  = pop_valid_q;
        pop_data_d   = pop_data_q;
        if (clr) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            pop_valid_d = 1'b0;
        end else begin
            wr_ptr_d     = wr_ptr_q + PW'(grant_wr);
            rd_ptr_d     = rd_ptr_q + PW'(grant_rd);
            ram_cnt_d    = ram_cnt_q + CW'(grant_wr) - CW'(grant_rd);
            last_grant_d = (want_wr & want_rd) ? (grant_wr ? GRANT_WR : GRANT_RD) : last_grant_q;
            state_d      = grant_rd ? RD : IDLE;
            pop_data_d   = (state_q == RD) ? ram_readdata : pop_data_q;
            pop_valid_d  = (state_q == RD) | (pop_valid_q & ~pop_ready);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_RD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            pop_valid_q  <= 1'b0;
            pop_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            pop_valid_q  <= pop_valid_d;
            pop_data_q   <= pop_data_d;
        end
    end
endmodule
